// File: rtl/fp_max_reduce_pkg.sv
`default_nettype none
// ============================================================================
// Module  : fp_max_reduce_pkg
// Purpose : Shared constants and state encoding for the FP max-reduction
//           block that feeds the softmax max-subtract stage.
//           - Default FP format (fp16: 1 sign, 5 exponent, 10 mantissa bits)
//           - Negative-infinity constant used as the reduction identity
//           - Controller state encoding (IDLE / ACCUM / DONE)
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package fp_max_reduce_pkg;

  // Default floating-point format
  localparam int C_DATAWIDTH       = 16;
  localparam int C_MANTISSA        = 10;
  localparam int C_EXPONENT        = 5;
  localparam int C_IEEE_COMPLIANCE = 0;
  localparam int C_LEN_W           = 8;

  // -inf in the default format: sign set, exponent all ones, mantissa zero.
  // It is the identity for max(), so it seeds the accumulator.
  localparam logic [C_DATAWIDTH-1:0] C_FP_NEG_INF =
    {1'b1, {C_EXPONENT{1'b1}}, {C_MANTISSA{1'b0}}};

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage : fp_max_reduce_pkg
`default_nettype wire

// File: rtl/fp_max_reduce_fp_max2.sv
`default_nettype none
// ============================================================================
// Module  : fp_max2
// Purpose : Combinational two-operand floating-point maximum. Returns the
//           larger of a_i and b_i; on a tie (including +0 vs -0) returns a_i,
//           so the caller decides tie priority by operand order.
//           With IEEE_COMPLIANCE != 0 a NaN operand loses to a non-NaN one;
//           with IEEE_COMPLIANCE == 0 operands are ordered purely by their
//           sign-magnitude encoding (NaN / denormal treated as plain codes).
// Ports   : a_i   in  DATAWIDTH  first operand (wins ties)
//           b_i   in  DATAWIDTH  second operand
//           max_o out DATAWIDTH  larger operand
// Rev     : 1.0  initial release
// ============================================================================
module fp_max2
  import fp_max_reduce_pkg::*;
#(
  parameter int DATAWIDTH       = C_DATAWIDTH,
  parameter int MANTISSA        = C_MANTISSA,
  parameter int EXPONENT        = C_EXPONENT,
  parameter int IEEE_COMPLIANCE = C_IEEE_COMPLIANCE
) (
  input  logic [DATAWIDTH-1:0] a_i,
  input  logic [DATAWIDTH-1:0] b_i,
  output logic [DATAWIDTH-1:0] max_o
);

  // Field split
  logic                w_a_sign;
  logic                w_b_sign;
  logic [EXPONENT-1:0] w_a_exp;
  logic [EXPONENT-1:0] w_b_exp;
  logic [MANTISSA-1:0] w_a_man;
  logic [MANTISSA-1:0] w_b_man;
  logic [DATAWIDTH-2:0] w_a_mag;
  logic [DATAWIDTH-2:0] w_b_mag;
  logic                w_a_zero;
  logic                w_b_zero;
  logic                w_b_gt_a;   // strict: b_i > a_i
  logic                w_sel_b;

  assign w_a_sign = a_i[DATAWIDTH-1];
  assign w_b_sign = b_i[DATAWIDTH-1];
  assign w_a_exp  = a_i[DATAWIDTH-2 -: EXPONENT];
  assign w_b_exp  = b_i[DATAWIDTH-2 -: EXPONENT];
  assign w_a_man  = a_i[MANTISSA-1:0];
  assign w_b_man  = b_i[MANTISSA-1:0];
  assign w_a_mag  = {w_a_exp, w_a_man};
  assign w_b_mag  = {w_b_exp, w_b_man};
  assign w_a_zero = (w_a_mag == '0);
  assign w_b_zero = (w_b_mag == '0);

  // Sign-magnitude ordering. Exponent sits above mantissa, so for operands
  // of equal sign the magnitude field compares as an unsigned integer; for
  // negatives the order is reversed. +0 and -0 compare equal.
  always_comb begin
    w_b_gt_a = 1'b0;
    if (w_a_zero && w_b_zero) begin
      w_b_gt_a = 1'b0;
    end else if (w_a_sign != w_b_sign) begin
      w_b_gt_a = w_a_sign;          // b is the non-negative one
    end else if (!w_a_sign) begin
      w_b_gt_a = (w_b_mag > w_a_mag);
    end else begin
      w_b_gt_a = (w_b_mag < w_a_mag);
    end
  end

  generate
    if (IEEE_COMPLIANCE != 0) begin : g_ieee
      logic w_a_nan;
      logic w_b_nan;
      assign w_a_nan = (&w_a_exp) && (w_a_man != '0);
      assign w_b_nan = (&w_b_exp) && (w_b_man != '0);
      // A NaN never wins against a number; two NaNs keep a_i.
      assign w_sel_b = (w_a_nan && !w_b_nan) ||
                       (!w_a_nan && !w_b_nan && w_b_gt_a);
    end else begin : g_raw
      assign w_sel_b = w_b_gt_a;
    end
  endgenerate

  assign max_o = w_sel_b ? b_i : a_i;

endmodule : fp_max2
`default_nettype wire

// File: rtl/fp_max_reduce.sv
`default_nettype none
// ============================================================================
// Module  : fp_max_reduce
// Purpose : Streams a vector two FP lanes per cycle and reduces it to its
//           maximum, then holds the result on max_out (with max_valid) for
//           the softmax subtract stage until that stage acknowledges it.
// Ports   : clk        in   1          clock, rising edge
//           reset      in   1          synchronous, active-high
//           start      in   1          begin a reduction (IDLE only)
//           num_pairs  in   LEN_W      lane pairs in the vector
//           in_valid   in   1          a_inp0/a_inp1 valid
//           in_ready   out  1          pair accepted when in_valid & in_ready
//           a_inp0     in   DATAWIDTH  lane 0 value
//           a_inp1     in   DATAWIDTH  lane 1 value
//           max_out    out  DATAWIDTH  reduced maximum (stable while valid)
//           max_valid  out  1          max_out is final
//           max_ack    in   1          consumer releases the result
//           busy       out  1          high in ACCUM or DONE
// Rev     : 1.0  initial release
// ============================================================================
module fp_max_reduce
  import fp_max_reduce_pkg::*;
#(
  parameter int DATAWIDTH       = C_DATAWIDTH,
  parameter int MANTISSA        = C_MANTISSA,
  parameter int EXPONENT        = C_EXPONENT,
  parameter int IEEE_COMPLIANCE = C_IEEE_COMPLIANCE,
  parameter int LEN_W           = C_LEN_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [LEN_W-1:0]     num_pairs,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATAWIDTH-1:0] a_inp0,
  input  logic [DATAWIDTH-1:0] a_inp1,
  output logic [DATAWIDTH-1:0] max_out,
  output logic                 max_valid,
  input  logic                 max_ack,
  output logic                 busy
);

  localparam logic [DATAWIDTH-1:0] C_NEG_INF =
    {1'b1, {EXPONENT{1'b1}}, {MANTISSA{1'b0}}};
  localparam logic [LEN_W-1:0] C_CNT_ONE = LEN_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e               state_q;
  logic [LEN_W-1:0]     cnt_q;        // pairs still to be accepted
  logic [DATAWIDTH-1:0] acc_q;        // running maximum, also max_out
  logic                 in_ready_q;
  logic                 max_valid_q;
  logic                 busy_q;

  // --------------------------------------------------------------------------
  // Datapath: max(acc, max(lane0, lane1)). Operand order sets tie priority:
  // lane 0 beats lane 1, and the accumulator beats the new pair.
  // --------------------------------------------------------------------------
  logic [DATAWIDTH-1:0] w_lane_max;
  logic [DATAWIDTH-1:0] acc_d;
  logic                 w_xfer;

  fp_max2 #(
    .DATAWIDTH      (DATAWIDTH),
    .MANTISSA       (MANTISSA),
    .EXPONENT       (EXPONENT),
    .IEEE_COMPLIANCE(IEEE_COMPLIANCE)
  ) u_max_lane (
    .a_i  (a_inp0),
    .b_i  (a_inp1),
    .max_o(w_lane_max)
  );

  fp_max2 #(
    .DATAWIDTH      (DATAWIDTH),
    .MANTISSA       (MANTISSA),
    .EXPONENT       (EXPONENT),
    .IEEE_COMPLIANCE(IEEE_COMPLIANCE)
  ) u_max_acc (
    .a_i  (acc_q),
    .b_i  (w_lane_max),
    .max_o(acc_d)
  );

  // in_ready_q is high exactly while in ACCUM, so this is the transfer.
  assign w_xfer = in_valid && in_ready_q;

  // --------------------------------------------------------------------------
  // Controller. Outputs are registered alongside the state so they change
  // only on clock edges. The accumulator doubles as max_out; it is written
  // only in IDLE (on start) and on transfers, so it is frozen in DONE.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= C_NEG_INF;
      in_ready_q  <= 1'b0;
      max_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q  <= C_NEG_INF;
            busy_q <= 1'b1;
            if (num_pairs != '0) begin
              cnt_q      <= num_pairs;
              in_ready_q <= 1'b1;
              state_q    <= ST_ACCUM;
            end else begin
              // Empty vector: result is the identity, available next cycle.
              cnt_q       <= '0;
              max_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end

        ST_ACCUM: begin
          if (w_xfer) begin
            acc_q <= acc_d;
            cnt_q <= cnt_q - C_CNT_ONE;
            if (cnt_q == C_CNT_ONE) begin
              in_ready_q  <= 1'b0;
              max_valid_q <= 1'b1;
              state_q     <= ST_DONE;
            end
          end
        end

        ST_DONE: begin
          // start is ignored here, even when it coincides with max_ack.
          if (max_ack) begin
            max_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end

        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b0;
          max_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign max_out   = acc_q;
  assign max_valid = max_valid_q;
  assign busy      = busy_q;

endmodule : fp_max_reduce
`default_nettype wire

// File: tb/tb_fp_max_reduce.sv
`default_nettype none
// ============================================================================
// Module  : tb_fp_max_reduce
// Purpose : Directed self-checking bench for fp_max_reduce (fp16 format).
// Rev     : 1.0  initial release
// ============================================================================
module tb_fp_max_reduce;

  logic        clk;
  logic        reset;
  logic        start;
  logic [7:0]  num_pairs;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_inp0;
  logic [15:0] a_inp1;
  logic [15:0] max_out;
  logic        max_valid;
  logic        max_ack;
  logic        busy;

  int total;
  int bad;

  fp_max_reduce u_dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_pairs(num_pairs),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_inp0   (a_inp0),
    .a_inp1   (a_inp1),
    .max_out  (max_out),
    .max_valid(max_valid),
    .max_ack  (max_ack),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Check the four observable outputs at once.
  task automatic chk_all(input string tag, input logic [15:0] e_out, input logic e_valid,
                         input logic e_ready, input logic e_busy);
    chk({tag, ".max_out"},   max_out,          e_out);
    chk({tag, ".max_valid"}, 16'(max_valid),   16'(e_valid));
    chk({tag, ".in_ready"},  16'(in_ready),    16'(e_ready));
    chk({tag, ".busy"},      16'(busy),        16'(e_busy));
  endtask

  task automatic begin_run(input logic [7:0] n);
    start = 1'b1; num_pairs = n;
    tick();
    start = 1'b0; num_pairs = 8'd0;
  endtask

  task automatic push(input logic [15:0] l0, input logic [15:0] l1);
    in_valid = 1'b1; a_inp0 = l0; a_inp1 = l1;
    tick();
    in_valid = 1'b0; a_inp0 = 16'h0; a_inp1 = 16'h0;
  endtask

  task automatic ack();
    max_ack = 1'b1;
    tick();
    max_ack = 1'b0;
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1; start = 1'b0; num_pairs = 8'd0; in_valid = 1'b0;
    a_inp0 = 16'h0; a_inp1 = 16'h0; max_ack = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk_all("reset", 16'hFC00, 1'b0, 1'b0, 1'b0);

    // 1: two pairs, result one cycle after the second transfer
    begin_run(8'd2);
    chk_all("t1.accum", 16'hFC00, 1'b0, 1'b1, 1'b1);
    push(16'h3C00, 16'h4000);
    chk("t1.mid_valid", 16'(max_valid), 16'd0);
    push(16'hC200, 16'h3800);
    chk_all("t1.done", 16'h4000, 1'b1, 1'b0, 1'b1);
    ack();
    chk_all("t1.idle", 16'h4000, 1'b0, 1'b0, 1'b0);

    // 2: in_valid pattern 1,0,0,1,1; ack during ACCUM must be ignored
    begin_run(8'd3);
    max_ack = 1'b1;
    push(16'h3C00, 16'h3800);
    chk("t2.busy1", 16'(busy), 16'd1);
    a_inp0 = 16'h7800; a_inp1 = 16'h7800; tick();
    chk("t2.busy2", 16'(busy), 16'd1);
    a_inp0 = 16'h7800; a_inp1 = 16'h7800; tick();
    chk_all("t2.stall", 16'h3C00, 1'b0, 1'b1, 1'b1);
    push(16'h4200, 16'h4000);
    chk_all("t2.third", 16'h4200, 1'b0, 1'b1, 1'b1);
    max_ack = 1'b0;
    push(16'h3E00, 16'h4400);
    chk_all("t2.done", 16'h4400, 1'b1, 1'b0, 1'b1);
    ack();

    // 3: all-negative pairs, then ties
    begin_run(8'd2);
    push(16'hC200, 16'hC400);
    push(16'hBC00, 16'hC000);
    chk_all("t3.neg", 16'hBC00, 1'b1, 1'b0, 1'b1);
    ack();
    begin_run(8'd1);
    push(16'h3C00, 16'h3C00);
    chk("t3.tie", max_out, 16'h3C00);
    ack();
    begin_run(8'd1);
    push(16'h8000, 16'h0000);            // -0 vs +0: lane 0 kept
    chk("t3.zero_lane", max_out, 16'h8000);
    ack();
    begin_run(8'd2);
    push(16'h0000, 16'h0000);
    push(16'h8000, 16'h8000);            // -0 vs acc +0: acc kept
    chk("t3.zero_acc", max_out, 16'h0000);
    ack();

    // 4: empty vector
    begin_run(8'd0);
    chk_all("t4.done", 16'hFC00, 1'b1, 1'b0, 1'b1);
    ack();
    chk_all("t4.idle", 16'hFC00, 1'b0, 1'b0, 1'b0);

    // 5: hold in DONE with start and data noise, then ack+start together
    begin_run(8'd1);
    push(16'h4000, 16'h3C00);
    start = 1'b1; num_pairs = 8'd5;
    in_valid = 1'b1; a_inp0 = 16'h7000; a_inp1 = 16'h7000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("t5.hold", 16'h4000, 1'b1, 1'b0, 1'b1);
    end
    in_valid = 1'b0;
    max_ack = 1'b1;
    tick();
    max_ack = 1'b0;
    chk_all("t5.ackstart", 16'h4000, 1'b0, 1'b0, 1'b0);
    start = 1'b0; num_pairs = 8'd0;
    tick();
    chk_all("t5.norun", 16'h4000, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-ACCUM, then a fresh run
    begin_run(8'd4);
    push(16'h3C00, 16'h3800);
    in_valid = 1'b1; a_inp0 = 16'h4000; a_inp1 = 16'h4000;
    reset = 1'b1;
    tick();
    reset = 1'b0; in_valid = 1'b0;
    chk_all("t6.reset", 16'hFC00, 1'b0, 1'b0, 1'b0);
    tick();
    chk("t6.quiet", 16'(max_valid), 16'd0);
    begin_run(8'd1);
    push(16'hC000, 16'h4500);
    chk_all("t6.rerun", 16'h4500, 1'b1, 1'b0, 1'b1);
    ack();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fp_max_reduce
`default_nettype wire
